// File: rtl/led_pio_arbiter_if.sv
// Request handshakes, status and Avalon-MM PIO signals of the LED arbiter.
// master = the arbiter itself, slave = the requesters plus the PIO peripheral.
interface led_pio_arbiter_if;
  logic        req0_valid;
  logic [7:0]  req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [7:0]  req1_data;
  logic        req1_ready;
  logic        hb_en;
  logic        err_clr;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic [7:0]  led_shadow;
  logic        busy;
  logic        mismatch;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, hb_en, err_clr, avm_readdata,
    output req0_ready, req1_ready, avm_address, avm_chipselect, avm_write_n,
    output avm_writedata, led_shadow, busy, mismatch
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, hb_en, err_clr, avm_readdata,
    input  req0_ready, req1_ready, avm_address, avm_chipselect, avm_write_n,
    input  avm_writedata, led_shadow, busy, mismatch
  );
endinterface

// File: rtl/led_pio_arbiter.sv
// Arbitrates alarm/status/heartbeat LED patterns onto an Avalon PIO with write-then-readback
// verification; every output is a flop, decoded from the next state.
module led_pio_arbiter #(
  parameter int PRESCALE    = 25000000,
  parameter int HOLD_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  led_pio_arbiter_if.master bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PW-1:0] PS_LAST   = PW'(PRESCALE - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WRITE, READ, HOLD} state_t;

  state_t        state, state_next;
  logic [PW-1:0] prescale_cnt;
  logic [HW-1:0] hold_cnt;
  logic          hb_pending;
  logic          grant_req0;
  logic          tick, xfer0, xfer1, ready_pending, hb_grant, mismatch_set;
  logic          load_shadow;
  logic [7:0]    shadow_next;
  logic          ready0_next, ready1_next, cs_next, write_n_next, busy_next;
  logic [23:0]   unused_readdata;

  assign tick          = (prescale_cnt == PS_LAST);
  assign xfer0         = bus.req0_ready && bus.req0_valid;
  assign xfer1         = bus.req1_ready && bus.req1_valid;
  assign ready_pending = bus.req0_ready || bus.req1_ready;
  assign hb_grant      = (state == IDLE) && !ready_pending && !bus.req0_valid &&
                         !bus.req1_valid && hb_pending;
  assign mismatch_set  = (state == READ) && (bus.avm_readdata[7:0] != bus.led_shadow);
  assign bus.avm_address = 2'b00;
  assign unused_readdata = bus.avm_readdata[31:8];

  // Ready is registered, so a request is decided one cycle and transferred the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      prescale_cnt       <= '0;
      hold_cnt           <= '0;
      hb_pending         <= 1'b0;
      grant_req0         <= 1'b0;
      bus.req0_ready     <= 1'b0;
      bus.req1_ready     <= 1'b0;
      bus.avm_chipselect <= 1'b0;
      bus.avm_write_n    <= 1'b1;
      bus.avm_writedata  <= '0;
      bus.led_shadow     <= '0;
      bus.busy           <= 1'b0;
      bus.mismatch       <= 1'b0;
    end else begin
      state              <= state_next;
      prescale_cnt       <= tick ? '0 : prescale_cnt + 1'b1;
      hold_cnt           <= (state == HOLD && state_next == HOLD) ? hold_cnt + 1'b1 : '0;
      bus.req0_ready     <= ready0_next;
      bus.req1_ready     <= ready1_next;
      bus.avm_chipselect <= cs_next;
      bus.avm_write_n    <= write_n_next;
      bus.busy           <= busy_next;

      // A tick landing on the grant cycle keeps the next heartbeat queued.
      if (!bus.hb_en)
        hb_pending <= 1'b0;
      else if (tick)
        hb_pending <= 1'b1;
      else if (hb_grant)
        hb_pending <= 1'b0;

      if (load_shadow) begin
        bus.led_shadow    <= shadow_next;
        bus.avm_writedata <= {24'b0, shadow_next};
        grant_req0        <= xfer0;
      end

      if (mismatch_set)
        bus.mismatch <= 1'b1;
      else if (bus.err_clr)
        bus.mismatch <= 1'b0;
    end
  end

  always_comb begin
    state_next  = state;
    load_shadow = 1'b0;
    shadow_next = bus.led_shadow;
    case (state)
      IDLE: begin
        if (xfer0) begin
          state_next  = WRITE;
          load_shadow = 1'b1;
          shadow_next = bus.req0_data;
        end else if (xfer1) begin
          state_next  = WRITE;
          load_shadow = 1'b1;
          shadow_next = bus.req1_data;
        end else if (hb_grant) begin
          state_next  = WRITE;
          load_shadow = 1'b1;
          shadow_next = bus.led_shadow ^ 8'h80;
        end
      end
      WRITE: state_next = READ;
      READ:  state_next = (grant_req0 && HOLD_CYCLES > 0) ? HOLD : IDLE;
      HOLD: begin
        if (xfer0) begin
          state_next  = WRITE;
          load_shadow = 1'b1;
          shadow_next = bus.req0_data;
        end else if (hold_cnt == HOLD_LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Only the alarm channel may be offered a ready while the hold is running.
  always_comb begin
    ready0_next  = 1'b0;
    ready1_next  = 1'b0;
    if (!ready_pending && (state == IDLE || state == HOLD))
      ready0_next = bus.req0_valid;
    if (!ready_pending && state == IDLE)
      ready1_next = !bus.req0_valid && bus.req1_valid;
    cs_next      = (state_next == WRITE) || (state_next == READ);
    write_n_next = (state_next != WRITE);
    busy_next    = (state_next != IDLE);
  end
endmodule
